// File: rtl/sa_feeder.sv
// Operand feeder for a 2x2 output-stationary systolic array: buffers K beats, then issues skewed rows/columns.
// Optional busy-cycle performance counter enabled by defining SA_FEEDER_PERF_EN.
module sa_feeder #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned K_DIM        = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a0,
  input  logic [DATA_WIDTH-1:0] in_a1,
  input  logic [DATA_WIDTH-1:0] in_b0,
  input  logic [DATA_WIDTH-1:0] in_b1,
  output logic [DATA_WIDTH-1:0] data_a_0_o,
  output logic [DATA_WIDTH-1:0] data_a_1_o,
  output logic [DATA_WIDTH-1:0] data_b_0_o,
  output logic [DATA_WIDTH-1:0] data_b_1_o,
  output logic                  acc_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           busy_cycles_o
);

  localparam int unsigned KW = $clog2(K_DIM + 1);
  localparam int unsigned IW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K_DIM);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [KW-1:0]   r_f, w_f_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  logic            w_accept;

  logic [DATA_WIDTH-1:0] r_a0 [K_DIM];
  logic [DATA_WIDTH-1:0] r_a1 [K_DIM];
  logic [DATA_WIDTH-1:0] r_b0 [K_DIM];
  logic [DATA_WIDTH-1:0] r_b1 [K_DIM];

  logic [DATA_WIDTH-1:0] r_da0, r_da1, r_db0, r_db1;
  logic [DATA_WIDTH-1:0] w_da0_nxt, w_da1_nxt, w_db0_nxt, w_db1_nxt;

  // r_k reaching K_LAST gives one closing LOAD cycle with in_ready low before FEED.
  assign in_ready = (r_state == S_LOAD) && (r_k != K_LAST);
  assign w_accept = in_ready && in_valid;

  assign acc_en_o = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_f     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_f     <= w_f_nxt;
      r_d     <= w_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_f_nxt     = r_f;
    w_d_nxt     = r_d;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = '0;
        end
      end
      S_LOAD: begin
        if (r_k == K_LAST) begin
          w_state_nxt = S_FEED;
          w_f_nxt     = '0;
          w_k_nxt     = '0;
        end else if (w_accept) begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_FEED: begin
        if (r_f == K_LAST) begin
          w_f_nxt = '0;
          w_d_nxt = '0;
          if (DRAIN_CYCLES == 0) w_state_nxt = S_DONE;
          else                   w_state_nxt = S_DRAIN;
        end else begin
          w_f_nxt = r_f + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_d == D_LAST) begin
          w_state_nxt = S_DONE;
          w_d_nxt     = '0;
        end else begin
          w_d_nxt = r_d + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded from the upcoming state/index so they align with FEED cycle f.
  always_comb begin
    w_da0_nxt = '0;
    w_da1_nxt = '0;
    w_db0_nxt = '0;
    w_db1_nxt = '0;
    if (w_state_nxt == S_FEED) begin
      if (w_f_nxt != K_LAST) begin
        w_da0_nxt = r_a0[IW'(w_f_nxt)];
        w_db0_nxt = r_b0[IW'(w_f_nxt)];
      end
      if (w_f_nxt != '0) begin
        w_da1_nxt = r_a1[IW'(w_f_nxt - 1'b1)];
        w_db1_nxt = r_b1[IW'(w_f_nxt - 1'b1)];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_da0 <= '0;
      r_da1 <= '0;
      r_db0 <= '0;
      r_db1 <= '0;
    end else begin
      r_da0 <= w_da0_nxt;
      r_da1 <= w_da1_nxt;
      r_db0 <= w_db0_nxt;
      r_db1 <= w_db1_nxt;
    end
  end

  assign data_a_0_o = r_da0;
  assign data_a_1_o = r_da1;
  assign data_b_0_o = r_db0;
  assign data_b_1_o = r_db1;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a0[IW'(r_k)] <= in_a0;
      r_a1[IW'(r_k)] <= in_a1;
      r_b0[IW'(r_k)] <= in_b0;
      r_b1[IW'(r_k)] <= in_b1;
    end
  end

`ifdef SA_FEEDER_PERF_EN
  logic [31:0] r_busy_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              r_busy_cnt <= '0;
    else if (busy_o && (r_busy_cnt != '1))  r_busy_cnt <= r_busy_cnt + 32'd1;
  end

  assign busy_cycles_o = r_busy_cnt;
`else
  assign busy_cycles_o = '0;
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder (K_DIM=2, DRAIN_CYCLES=2) with a 2x2 systolic array model as consumer.
module tb_sa_feeder;

  logic        clk = 1'b0;
  logic        rstn, start, in_valid, in_ready;
  logic [15:0] in_a0, in_a1, in_b0, in_b1;
  logic [15:0] da0, da1, db0, db1;
  logic        acc_en, busy, done;
  logic [31:0] busy_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  bit tmo     = 1'b0;

`ifdef SA_FEEDER_PERF_EN
  localparam logic [31:0] EXP_BUSY = 32'd9;
`else
  localparam logic [31:0] EXP_BUSY = 32'd0;
`endif

  always #5 clk = ~clk;

  sa_feeder #(.DATA_WIDTH(16), .K_DIM(2), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .data_a_0_o(da0), .data_a_1_o(da1), .data_b_0_o(db0), .data_b_1_o(db1),
    .acc_en_o(acc_en), .busy_o(busy), .done_o(done), .busy_cycles_o(busy_cycles)
  );

  // 2x2 output-stationary array: A flows right, B flows down, one register per hop.
  logic signed [15:0] pa00, pb00, pa10, pb01;
  logic signed [31:0] acc00, acc01, acc10, acc11;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pa00 <= '0; pb00 <= '0; pa10 <= '0; pb01 <= '0;
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
    end else begin
      pa00 <= $signed(da0);
      pb00 <= $signed(db0);
      pa10 <= $signed(da1);
      pb01 <= $signed(db1);
      if (start && !busy) begin
        acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
      end else if (acc_en) begin
        acc00 <= acc00 + $signed(da0) * $signed(db0);
        acc01 <= acc01 + pa00 * $signed(db1);
        acc10 <= acc10 + $signed(da1) * pb00;
        acc11 <= acc11 + pa10 * pb01;
      end
    end
  end

  logic [15:0] bt_a0 [2], bt_a1 [2], bt_b0 [2], bt_b1 [2];
  logic [15:0] cap [8][4];
  int          n_acc, done_at, n_done, rdy_bad;
  logic        ready_after_last;

  task automatic set_beats(input logic [15:0] p0a0, p0a1, p0b0, p0b1,
                           input logic [15:0] p1a0, p1a1, p1b0, p1b1);
    bt_a0[0] = p0a0; bt_a1[0] = p0a1; bt_b0[0] = p0b0; bt_b1[0] = p0b1;
    bt_a0[1] = p1a0; bt_a1[1] = p1a1; bt_b0[1] = p1b0; bt_b1[1] = p1b1;
  endtask

  // Returns at the negedge of the first FEED cycle.
  task automatic start_and_load(input int gap, input bit do_start, input bit hold);
    int w;
    if (do_start) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); if (!hold) start = 1'b0;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_a0 = bt_a0[k]; in_a1 = bt_a1[k]; in_b0 = bt_b0[k]; in_b1 = bt_b1[k];
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      if (w >= 20) tmo = 1'b1;
      @(negedge clk);
    end
    ready_after_last = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic watch_to_done();
    n_acc = 0; done_at = 0; n_done = 0; rdy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (acc_en) begin
        if (n_acc < 8) begin
          cap[n_acc][0] = da0; cap[n_acc][1] = da1; cap[n_acc][2] = db0; cap[n_acc][3] = db1;
        end
        n_acc++;
      end
      if ((acc_en || done) && in_ready) rdy_bad++;
      if (done) begin done_at = c; n_done++; break; end
      @(negedge clk);
    end
    if (n_done == 0) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;
    repeat (3) @(negedge clk);
    n_tests++; if ({da0, da1, db0, db1} !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {da0, da1, db0, db1}); end
    n_tests++; if ({in_ready, acc_en, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, acc_en, busy, done}); end
    n_tests++; if (busy_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d expected 0", busy_cycles); end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++; if ({in_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 00", {in_ready, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ef [3][4];
    ef = '{'{16'd1, 16'd0, 16'd5, 16'd0}, '{16'd2, 16'd3, 16'd7, 16'd6}, '{16'd0, 16'd4, 16'd0, 16'd8}};
    set_beats(16'd1, 16'd3, 16'd5, 16'd6, 16'd2, 16'd4, 16'd7, 16'd8);
    start_and_load(0, 1'b1, 1'b0);
    watch_to_done();
    n_tests++; if (ready_after_last !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra_beat: got %b expected 0", ready_after_last); end
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++) begin
        n_tests++; if (cap[f][j] !== ef[f][j]) begin n_fail++; $display("FAIL b2b_feed f%0d lane%0d: got %0d expected %0d", f, j, cap[f][j], ef[f][j]); end
      end
    n_tests++; if (n_acc !== 5) begin n_fail++; $display("FAIL b2b_acc_en_cycles: got %0d expected 5", n_acc); end
    n_tests++; if (done_at !== 6) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 6", done_at); end
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
      n_fail++; $display("FAIL b2b_accum: got %0d %0d %0d %0d expected 19 22 43 50", acc00, acc01, acc10, acc11); end
    @(negedge clk);
    n_tests++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL b2b_after_done: got %b expected 00", {done, busy}); end
    n_tests++; if (busy_cycles !== EXP_BUSY) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cycles, EXP_BUSY); end
  endtask

  task automatic test_stall_gaps();
    logic [15:0] ef [3][4];
    ef = '{'{16'd1, 16'd0, 16'd5, 16'd0}, '{16'd2, 16'd3, 16'd7, 16'd6}, '{16'd0, 16'd4, 16'd0, 16'd8}};
    set_beats(16'd1, 16'd3, 16'd5, 16'd6, 16'd2, 16'd4, 16'd7, 16'd8);
    start_and_load(3, 1'b1, 1'b0);
    watch_to_done();
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++) begin
        n_tests++; if (cap[f][j] !== ef[f][j]) begin n_fail++; $display("FAIL gap_feed f%0d lane%0d: got %0d expected %0d", f, j, cap[f][j], ef[f][j]); end
      end
    n_tests++; if (done_at !== 6) begin n_fail++; $display("FAIL gap_done_cycle: got %0d expected 6", done_at); end
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
      n_fail++; $display("FAIL gap_accum: got %0d %0d %0d %0d expected 19 22 43 50", acc00, acc01, acc10, acc11); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [15:0] ef [3][4];
    ef = '{'{16'hFFFF, 16'd0, 16'd5, 16'd0}, '{16'd2, 16'd3, 16'hFFF9, 16'hFFFA}, '{16'd0, 16'hFFFC, 16'd0, 16'd8}};
    set_beats(16'hFFFF, 16'd3, 16'd5, 16'hFFFA, 16'd2, 16'hFFFC, 16'hFFF9, 16'd8);
    start_and_load(0, 1'b1, 1'b0);
    watch_to_done();
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++) begin
        n_tests++; if (cap[f][j] !== ef[f][j]) begin n_fail++; $display("FAIL signed_feed f%0d lane%0d: got %h expected %h", f, j, cap[f][j], ef[f][j]); end
      end
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {-32'sd19, 32'sd22, 32'sd43, -32'sd50}) begin
      n_fail++; $display("FAIL signed_accum: got %0d %0d %0d %0d expected -19 22 43 -50", acc00, acc01, acc10, acc11); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    set_beats(16'd1, 16'd3, 16'd5, 16'd6, 16'd2, 16'd4, 16'd7, 16'd8);
    start_and_load(0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if ({acc_en, da0, da1, db0, db1} !== {1'b1, 16'd2, 16'd3, 16'd7, 16'd6}) begin
      n_fail++; $display("FAIL mid_pre_reset_f1: got %h expected 10002000300070006", {acc_en, da0, da1, db0, db1}); end
    rstn = 1'b0;
    #1;
    n_tests++; if ({da0, da1, db0, db1} !== 64'd0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 0", {da0, da1, db0, db1}); end
    n_tests++; if ({in_ready, acc_en, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 0000", {in_ready, acc_en, busy, done}); end
    n_tests++; if (busy_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_busy_cycles: got %0d expected 0", busy_cycles); end
    @(negedge clk);
    rstn = 1'b1;
    set_beats(16'd2, 16'd1, 16'd3, 16'd1, 16'd1, 16'd2, 16'd4, 16'd2);
    start_and_load(0, 1'b1, 1'b0);
    watch_to_done();
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {32'sd10, 32'sd4, 32'sd11, 32'sd5}) begin
      n_fail++; $display("FAIL post_reset_accum: got %0d %0d %0d %0d expected 10 4 11 5", acc00, acc01, acc10, acc11); end
    n_tests++; if (done_at !== 6) begin n_fail++; $display("FAIL post_reset_done_cycle: got %0d expected 6", done_at); end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    set_beats(16'd1, 16'd3, 16'd5, 16'd6, 16'd2, 16'd4, 16'd7, 16'd8);
    start_and_load(0, 1'b1, 1'b1);
    watch_to_done();
    n_tests++; if (n_done !== 1 || rdy_bad !== 0) begin n_fail++; $display("FAIL held_job1: got done=%0d rdy_bad=%0d expected 1 0", n_done, rdy_bad); end
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
      n_fail++; $display("FAIL held_accum1: got %0d %0d %0d %0d expected 19 22 43 50", acc00, acc01, acc10, acc11); end
    @(negedge clk);
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL held_idle_gap: got %b expected 00", {busy, done}); end
    @(negedge clk);
    n_tests++; if ({busy, in_ready} !== 2'b11) begin n_fail++; $display("FAIL held_restart: got %b expected 11", {busy, in_ready}); end
    set_beats(16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1);
    start_and_load(0, 1'b0, 1'b0);
    watch_to_done();
    n_tests++; if (n_done !== 1 || rdy_bad !== 0) begin n_fail++; $display("FAIL held_job2: got done=%0d rdy_bad=%0d expected 1 0", n_done, rdy_bad); end
    n_tests++; if ({acc00, acc01, acc10, acc11} !== {32'sd1, 32'sd0, 32'sd0, 32'sd1}) begin
      n_fail++; $display("FAIL held_accum2: got %0d %0d %0d %0d expected 1 0 0 1", acc00, acc01, acc10, acc11); end
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_no_third_job: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_gaps();
    test_signed();
    test_reset_mid_job();
    test_start_held();
    n_tests++;
    if (tmo) begin n_fail++; $display("FAIL handshake_timeout: got 1 expected 0"); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
